// File: rtl/reg_dump_seq_pkg.sv
// Shared definitions for the register dump sequencer and its register file.
package reg_dump_seq_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage : reg_dump_seq_pkg

// File: rtl/reg_dump_seq.sv
// Register dump sequencer: walks register indices 0..NUM_REGS-1, capturing
// each value from the register file in its own LOAD cycle and presenting it
// as a valid/ready beat. All outputs except rr are registered; rr follows the
// index register directly.
module reg_dump_seq
    import reg_dump_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rr,
    input  logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_idx_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    // Sequencer FSM with inline index counter and registered beat/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    out_data_q  <= rd;
                    out_idx_q   <= idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            // Index stays on the last register until DONE exits.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    // Clearing the index here keeps rr at 0 whenever idle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rr        = idx_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : reg_dump_seq

// File: tb/tb_reg_dump_seq.sv
// Directed bench for reg_dump_seq: per-cycle vector table plus hand-written
// reset-abort and single-register sequences.
module tb_reg_dump_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] rr;
    logic [7:0] rd;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic       start2;
    logic [1:0] rr2;
    logic [7:0] rd2;
    logic [7:0] out_data2;
    logic [1:0] out_idx2;
    logic       out_valid2;
    logic       out_ready2;
    logic       busy2;
    logic       done2;

    logic [7:0] rf [4];

    int unsigned n_pass;
    int unsigned n_total;

    typedef struct {
        logic       st;
        logic       rdy;
        logic       wr;
        logic       v;
        logic [1:0] idx;
        logic [7:0] dat;
        logic       bsy;
        logic       dn;
        logic [1:0] rr;
    } vec_t;

    vec_t tbl[$];

    reg_dump_seq #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rr(rr), .rd(rd),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    reg_dump_seq #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rr(rr2), .rd(rd2),
        .out_data(out_data2), .out_idx(out_idx2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    always_comb rd  = rf[rr];
    always_comb rd2 = rf[rr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic st, input logic rdy, input logic wr,
                                input logic v, input logic [1:0] idx, input logic [7:0] dat,
                                input logic bsy, input logic dn, input logic [1:0] r);
        vec_t e;
        e.st = st; e.rdy = rdy; e.wr = wr; e.v = v; e.idx = idx;
        e.dat = dat; e.bsy = bsy; e.dn = dn; e.rr = r;
        tbl.push_back(e);
    endfunction

    task automatic preload();
        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
    endtask

    initial begin
        int unsigned beats;
        int unsigned dones;
        int unsigned bad_busy;
        n_pass = 0;
        n_total = 0;
        preload();
        start = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; out_ready2 = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy",      32'(busy), 0);
        chk("rst done",      32'(done), 0);
        chk("rst rr",        32'(rr), 0);
        chk("rst out_data",  32'(out_data), 0);
        chk("rst out_idx",   32'(out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full dump, ready held high
        add(1,1,0, 0,0,8'h00,1,0,0);
        add(0,1,0, 1,0,8'h11,1,0,0);
        add(0,1,0, 0,0,8'h00,1,0,1);
        add(0,1,0, 1,1,8'h22,1,0,1);
        add(0,1,0, 0,0,8'h00,1,0,2);
        add(0,1,0, 1,2,8'h33,1,0,2);
        add(0,1,0, 0,0,8'h00,1,0,3);
        add(0,1,0, 1,3,8'h44,1,0,3);
        add(0,1,0, 0,0,8'h00,1,1,3);
        add(0,1,0, 0,0,8'h00,0,0,0);
        // Stall on beat 1 for three cycles; ready low outside SEND is ignored
        add(1,0,0, 0,0,8'h00,1,0,0);
        add(0,0,0, 1,0,8'h11,1,0,0);
        add(0,1,0, 0,0,8'h00,1,0,1);
        add(0,0,0, 1,1,8'h22,1,0,1);
        add(0,0,0, 1,1,8'h22,1,0,1);
        add(0,0,0, 1,1,8'h22,1,0,1);
        add(0,0,0, 1,1,8'h22,1,0,1);
        add(0,1,0, 0,0,8'h00,1,0,2);
        add(0,1,0, 1,2,8'h33,1,0,2);
        add(0,1,0, 0,0,8'h00,1,0,3);
        add(0,1,0, 1,3,8'h44,1,0,3);
        add(0,1,0, 0,0,8'h00,1,1,3);
        add(0,1,0, 0,0,8'h00,0,0,0);
        // Start while busy (beat 2 and DONE) is neither honoured nor queued
        add(1,1,0, 0,0,8'h00,1,0,0);
        add(0,1,0, 1,0,8'h11,1,0,0);
        add(0,1,0, 0,0,8'h00,1,0,1);
        add(0,1,0, 1,1,8'h22,1,0,1);
        add(1,1,0, 0,0,8'h00,1,0,2);
        add(1,1,0, 1,2,8'h33,1,0,2);
        add(0,1,0, 0,0,8'h00,1,0,3);
        add(0,1,0, 1,3,8'h44,1,0,3);
        add(0,1,0, 0,0,8'h00,1,1,3);
        add(1,1,0, 0,0,8'h00,0,0,0);
        add(0,1,0, 0,0,8'h00,0,0,0);
        // Register write during beat 1 shows up in beat 3
        add(1,1,0, 0,0,8'h00,1,0,0);
        add(0,1,0, 1,0,8'h11,1,0,0);
        add(0,1,0, 0,0,8'h00,1,0,1);
        add(0,1,0, 1,1,8'h22,1,0,1);
        add(0,1,1, 0,0,8'h00,1,0,2);
        add(0,1,0, 1,2,8'h33,1,0,2);
        add(0,1,0, 0,0,8'h00,1,0,3);
        add(0,1,0, 1,3,8'h99,1,0,3);
        add(0,1,0, 0,0,8'h00,1,1,3);
        add(0,1,0, 0,0,8'h00,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st;
            out_ready = tbl[i].rdy;
            if (tbl[i].wr) rf[3] = 8'h99;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].bsy));
            chk($sformatf("row%0d done", i),      32'(done),      32'(tbl[i].dn));
            chk($sformatf("row%0d rr", i),        32'(rr),        32'(tbl[i].rr));
            chk($sformatf("row%0d done&valid", i), 32'(done & out_valid), 0);
            if (tbl[i].v) begin
                chk($sformatf("row%0d out_idx", i),  32'(out_idx),  32'(tbl[i].idx));
                chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].dat));
            end
        end
        start = 1'b0;

        // Reset asserted mid-SEND of beat 2 aborts the sequence
        preload();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("abort pre valid", 32'(out_valid), 1);
        chk("abort pre idx",   32'(out_idx), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(out_valid), 0);
        chk("abort busy",  32'(busy), 0);
        chk("abort rr",    32'(rr), 0);
        chk("abort done",  32'(done), 0);
        chk("abort data",  32'(out_data), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        dones = 0;
        bad_busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) bad_busy++;
        end
        chk("abort no done", dones, 0);
        chk("abort stays idle", bad_busy, 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart busy", 32'(busy), 1);
        beats = 0;
        dones = 0;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                chk($sformatf("restart beat%0d idx", beats), 32'(out_idx), beats);
                chk($sformatf("restart beat%0d data", beats), 32'(out_data), 32'(rf[beats[1:0]]));
                beats++;
            end
            if (done) dones++;
        end
        chk("restart beats", beats, 4);
        chk("restart dones", dones, 1);
        @(posedge clk); #1;
        chk("restart idle", 32'(busy), 0);

        // Single-register instance
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("n1 load busy",  32'(busy2), 1);
        chk("n1 load valid", 32'(out_valid2), 0);
        @(posedge clk); #1;
        chk("n1 beat valid", 32'(out_valid2), 1);
        chk("n1 beat idx",   32'(out_idx2), 0);
        chk("n1 beat data",  32'(out_data2), 32'h11);
        @(posedge clk); #1;
        chk("n1 done",       32'(done2), 1);
        chk("n1 done valid", 32'(out_valid2), 0);
        chk("n1 done rr",    32'(rr2), 0);
        @(posedge clk); #1;
        chk("n1 idle done",  32'(done2), 0);
        chk("n1 idle busy",  32'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_reg_dump_seq
